// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store at a time,
// waits LATENCY cycles, performs the access and pulses a single-cycle response.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_INIT  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        valid_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          reqErr;
    logic          doAccess;
    logic          memWe;
    logic [AW-1:0] wordIdx;
    logic          unusedAddrBits;

    assign reqErr   = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);
    assign wordIdx  = addr_q[AW+1:2];
    assign doAccess = (state_q == WAIT) && (cnt_q == 4'd0);
    assign memWe    = doAccess && write_q;

    // Alignment and range were already judged on the live request at accept time.
    assign unusedAddrBits = ^{addr_q[31:AW+2], addr_q[1:0]};

    assign req_ready  = (state_q == IDLE);
    assign stall      = ((state_q == IDLE) && req_valid) || (state_q == WAIT);
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (memWe) begin
            mem_q[wordIdx] <= wdata_q;
        end
    end

    // Error requests skip WAIT entirely; legal ones touch storage only on the WAIT->RESP edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (reqErr) begin
                            state_q <= RESP;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                        err_q   <= 1'b0;
                        rdata_q <= write_q ? 32'd0 : mem_q[wordIdx];
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Drives three responders (LATENCY 2, 1, 15) with identical traffic and compares
// each against a word-array reference model of the memory and its response timing.
module tb_data_mem_responder;

    localparam int LATS [3] = '{2, 1, 15};
    localparam int DEPTH    = 256;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [2:0]  readyV;
    logic [2:0]  rvV;
    logic [2:0]  errV;
    logic [2:0]  stallV;
    logic [31:0] rdV [3];

    logic [31:0] modelMem [DEPTH];
    int          checks;
    int          failures;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATS[0])) u0 (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(readyV[0]),
        .resp_valid(rvV[0]), .resp_rdata(rdV[0]), .resp_err(errV[0]), .stall(stallV[0]));

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATS[1])) u1 (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(readyV[1]),
        .resp_valid(rvV[1]), .resp_rdata(rdV[1]), .resp_err(errV[1]), .stall(stallV[1]));

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATS[2])) u2 (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(readyV[2]),
        .resp_valid(rvV[2]), .resp_rdata(rdV[2]), .resp_err(errV[2]), .stall(stallV[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on all three DUTs; mode 0 = idle inputs after accept,
    // 1 = random inputs (valid included), 2 = shift addr by 4 and wdata to 2.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int mode);
        bit          done [3];
        int          stallCnt [3];
        bit          legal;
        bit          anyDone;
        int          idx;
        logic [31:0] expData;
        legal   = (addr[1:0] == 2'b00) && (addr < 32'(DEPTH * 4));
        idx     = int'(addr[31:2]);
        expData = (legal && !wr) ? modelMem[idx] : 32'd0;
        if (legal && wr) modelMem[idx] = wdata;

        reqValid = 1'b1;
        reqWrite = wr;
        reqAddr  = addr;
        reqWdata = wdata;
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("ready_before_accept[%0d]", d), 32'(readyV[d]), 32'd1);
            stallCnt[d] = int'(stallV[d]);
            done[d]     = 1'b0;
        end
        @(posedge clk);
        #1;
        reqValid = (mode == 1) ? 1'($urandom) : 1'b0;
        reqWrite = 1'($urandom);
        reqAddr  = (mode == 2) ? addr + 32'd4 : $urandom;
        reqWdata = (mode == 2) ? 32'd2 : $urandom;

        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            anyDone = 1'b0;
            for (int d = 0; d < 3; d++) begin
                if (!done[d] && rvV[d]) begin
                    done[d] = 1'b1;
                    checkOutput($sformatf("latency[%0d]", d), 32'(n + 1),
                                legal ? 32'(LATS[d] + 1) : 32'd1);
                    checkOutput($sformatf("resp_err[%0d]", d), 32'(errV[d]), legal ? 32'd0 : 32'd1);
                    checkOutput($sformatf("resp_rdata[%0d]", d), rdV[d], expData);
                    checkOutput($sformatf("stall_in_resp[%0d]", d), 32'(stallV[d]), 32'd0);
                    checkOutput($sformatf("stall_cycles[%0d]", d), 32'(stallCnt[d]),
                                legal ? 32'(LATS[d] + 1) : 32'd1);
                end else if (!done[d]) begin
                    stallCnt[d] += int'(stallV[d]);
                end
                anyDone |= done[d];
            end
            if (done[0] && done[1] && done[2]) break;
            reqValid = (mode == 1 && !anyDone) ? 1'($urandom) : 1'b0;
            if (mode == 1) begin
                reqAddr  = $urandom;
                reqWdata = $urandom;
            end
        end
        for (int d = 0; d < 3; d++) begin
            if (!done[d]) checkOutput($sformatf("resp_timeout[%0d]", d), 32'd0, 32'd1);
        end
        reqValid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("resp_pulse_width[%0d]", d), 32'(rvV[d]), 32'd0);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("%s_resp_valid[%0d]", tag, d), 32'(rvV[d]), 32'd0);
            checkOutput($sformatf("%s_resp_err[%0d]", tag, d), 32'(errV[d]), 32'd0);
            checkOutput($sformatf("%s_resp_rdata[%0d]", tag, d), rdV[d], 32'd0);
            checkOutput($sformatf("%s_ready[%0d]", tag, d), 32'(readyV[d]), 32'd1);
            checkOutput($sformatf("%s_stall[%0d]", tag, d), 32'(stallV[d]), 32'(reqValid));
        end
    endtask

    function automatic logic [31:0] randAddr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        if (sel == 1) return 32'(DEPTH * 4) + ($urandom & 32'h0000_fffc);
        if (sel == 2) return 32'($urandom_range(0, DEPTH - 1)) << 2;
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'd0;
        rst      = 1'b0;
        reqValid = 1'b0;
        reqWrite = 1'b0;
        reqAddr  = 32'd0;
        reqWdata = 32'd0;

        // Reset state, then a valid request held through reset must not be taken.
        repeat (2) @(negedge clk);
        checkResetOutputs("reset_idle");
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqAddr  = 32'h10;
        reqWdata = 32'h1234_5678;
        #1;
        checkResetOutputs("reset_valid");
        @(negedge clk);
        checkResetOutputs("reset_held");
        reqValid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);

        // Store then load at 0x10, then a misaligned load and a re-read.
        applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
        applyStimulus(1'b0, 32'h10, 32'h0, 0);
        applyStimulus(1'b0, 32'h13, 32'h0, 0);
        applyStimulus(1'b0, 32'h10, 32'h0, 0);

        // Out-of-range store must leave every word untouched.
        applyStimulus(1'b1, 32'h400, 32'hFFFF_FFFF, 0);
        for (int w = 0; w < DEPTH; w++) applyStimulus(1'b0, 32'(w) << 2, 32'h0, 0);

        // Inputs changing during WAIT must not redirect the store.
        applyStimulus(1'b1, 32'h20, 32'h1, 2);
        applyStimulus(1'b0, 32'h20, 32'h0, 0);
        applyStimulus(1'b0, 32'h24, 32'h0, 0);

        // Reset in the middle of WAIT aborts the store and clears storage.
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqAddr  = 32'h8;
        reqWdata = 32'h55;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'd0;
        #1;
        checkResetOutputs("abort");
        repeat (2) begin
            @(negedge clk);
            checkResetOutputs("abort_hold");
        end
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 32'h8, 32'h0, 0);
        applyStimulus(1'b0, 32'h10, 32'h0, 0);

        // Randomized traffic with random input noise after accept.
        for (int t = 0; t < 150; t++) begin
            applyStimulus(1'($urandom), randAddr(), $urandom, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
